// File: rtl/paralelo_serial_param_pkg.sv
// Shared constants for the parallel-to-serial transmitter: default comma and
// idle words and the link FSM state encodings.
package paralelo_serial_param_pkg;

    // Default comma word, repeated while the link is synchronising.
    localparam logic [7:0] PS_COM_DEFAULT = 8'hBC;

    // Default idle word, sent in RUN whenever no data word is offered.
    localparam logic [7:0] PS_IDL_DEFAULT = 8'h7C;

    // Link FSM state encodings.
    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/paralelo_serial_param_shift.sv
// Shift register and bit counter for the serialiser. Holds the word being
// sent, counts bits within it and flags the last bit of every word
// (the word boundary) so the owner can supply the next word.
module ps_shift_reg #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_WORD = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] next_word,
    output logic             msb,
    output logic             boundary
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_r;
    logic [CW-1:0]    bit_cnt_r;
    logic             boundary_s;

    assign boundary_s = (bit_cnt_r == LAST_BIT);
    assign boundary   = boundary_s;
    assign msb        = sh_r[WIDTH-1];

    // Shift one bit per clock; at the word boundary load the next word and restart the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_r      <= RST_WORD;
            bit_cnt_r <= {CW{1'b0}};
        end else if (boundary_s) begin
            sh_r      <= next_word;
            bit_cnt_r <= {CW{1'b0}};
        end else begin
            sh_r      <= {sh_r[WIDTH-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial link transmitter. Sends a run of comma words until the
// receiver has had time to align, then switches to RUN and sends data words
// (or idle words when nothing is offered), MSB first, one bit per clock.
// All decisions are taken only at word boundaries so every word is sent whole.
module paralelo_serial_param
    import paralelo_serial_param_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(PS_COM_DEFAULT),
    parameter logic [WIDTH-1:0] IDL        = WIDTH'(PS_IDL_DEFAULT),
    parameter int               SYNC_WORDS = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             active,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             serial_out,
    output logic             load_req,
    output logic             sync_done
);

    // Counter wide enough to hold SYNC_WORDS itself (it saturates there).
    localparam int CNT_W = $clog2(SYNC_WORDS + 1);
    localparam logic [CNT_W-1:0] SYNC_MAX    = CNT_W'(SYNC_WORDS);
    localparam logic [CNT_W:0]   SYNC_TARGET = (CNT_W + 1)'(SYNC_WORDS);

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic [CNT_W-1:0] sync_cnt_r;
    logic [CNT_W-1:0] sync_cnt_nxt_s;
    logic [CNT_W:0]   sync_inc_s;
    logic             sync_reached_s;
    logic [WIDTH-1:0] next_word_s;
    logic             boundary_s;
    logic             msb_s;

    ps_shift_reg #(
        .WIDTH    (WIDTH),
        .RST_WORD (COM)
    ) u_shift (
        .clk       (clk_32f),
        .reset     (reset),
        .next_word (next_word_s),
        .msb       (msb_s),
        .boundary  (boundary_s)
    );

    // Comma count including the word finishing now; the extra bit avoids overflow at the limit.
    assign sync_inc_s     = {1'b0, sync_cnt_r} + (CNT_W + 1)'(1);
    assign sync_reached_s = (sync_inc_s >= SYNC_TARGET);

    // Choose the next word and the next FSM/counter values for the coming boundary.
    always_comb begin
        state_nxt_s    = state_r;
        sync_cnt_nxt_s = sync_cnt_r;
        next_word_s    = COM;
        case (state_r)
            ST_SYNC: begin
                sync_cnt_nxt_s = sync_reached_s ? SYNC_MAX : sync_inc_s[CNT_W-1:0];
                if (active && sync_reached_s) begin
                    state_nxt_s = ST_RUN;
                    next_word_s = IDL;
                end else begin
                    state_nxt_s = ST_SYNC;
                    next_word_s = COM;
                end
            end
            ST_RUN: begin
                if (active) begin
                    state_nxt_s = ST_RUN;
                    next_word_s = valid_in ? data_in : IDL;
                end else begin
                    // Link dropped: restart alignment from scratch.
                    state_nxt_s    = ST_SYNC;
                    next_word_s    = COM;
                    sync_cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s    = ST_SYNC;
                next_word_s    = COM;
                sync_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and comma counter only move at word boundaries.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_r    <= ST_SYNC;
            sync_cnt_r <= {CNT_W{1'b0}};
        end else if (boundary_s) begin
            state_r    <= state_nxt_s;
            sync_cnt_r <= sync_cnt_nxt_s;
        end else begin
            state_r    <= state_r;
            sync_cnt_r <= sync_cnt_r;
        end
    end

    assign serial_out = msb_s;
    assign sync_done  = (state_r == ST_RUN);
    assign load_req   = (state_r == ST_RUN) && active && boundary_s;

endmodule
